// File: rtl/uart_pkg.sv
// Shared UART receive-side types: data width, host buffer occupancy states and sticky status.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic overrun;
        logic framing;
    } rx_status_t;

endpackage

// File: rtl/rx_fifo_mem.sv
// Register-array storage for the receive FIFO: one synchronous write port, one combinational read port.
module rx_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    // Contents are intentionally not reset; occupancy lives in the controller.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rx_host_buffer_ctrl.sv
// Host-side receive buffer controller: captures words strobed by the RCU into a small FIFO,
// sequences host reads and keeps sticky overrun/framing status until the host clears it.
//
//   state   | meaning
//   EMPTY   | no stored words, data_ready low
//   PARTIAL | 1..DEPTH-1 stored words
//   FULL    | DEPTH stored words, further pushes without a pop overrun
module rx_host_buffer_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     load_buffer,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic                     framing_error,
    input  logic                     data_read,
    input  logic                     clear_errors,
    output logic [DATA_W-1:0]        rx_out,
    output logic                     data_ready,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun_error,
    output logic                     framing_flag
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH_1 = CW'(DEPTH - 1);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    buf_state_t        state;
    buf_state_t        state_nxt;
    rx_status_t        status;
    rx_status_t        status_nxt;
    logic              push_req;
    logic              do_push;
    logic              do_pop;
    logic [DATA_W-1:0] head_word;

    assign push_req = load_buffer & ~framing_error;
    assign do_pop   = data_read & (state != EMPTY);
    // A full FIFO still accepts a push when the host frees a slot in the same cycle.
    assign do_push  = push_req & ((state != FULL) | do_pop);

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (do_push) state_nxt = PARTIAL;
            end
            PARTIAL: begin
                if (do_pop && !do_push && cnt == CNT_ONE)
                    state_nxt = EMPTY;
                else if (do_push && !do_pop && cnt == CNT_DEPTH_1)
                    state_nxt = FULL;
            end
            FULL: begin
                if (do_pop && !do_push) state_nxt = PARTIAL;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Error events take priority over a simultaneous clear.
    always_comb begin
        status_nxt         = status;
        status_nxt.overrun = (status.overrun & ~clear_errors)
                           | (push_req & (state == FULL) & ~do_pop);
        status_nxt.framing = (status.framing & ~clear_errors)
                           | (load_buffer & framing_error);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            state  <= EMPTY;
            status <= '0;
        end else begin
            state  <= state_nxt;
            status <= status_nxt;
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    rx_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (do_push),
        .waddr (wr_ptr),
        .wdata (rx_data),
        .raddr (rd_ptr),
        .rdata (head_word)
    );

    assign data_ready    = (state != EMPTY);
    assign fifo_full     = (state == FULL);
    assign count         = cnt;
    assign rx_out        = data_ready ? head_word : '0;
    assign overrun_error = status.overrun;
    assign framing_flag  = status.framing;

endmodule

// File: tb/tb_rx_host_buffer_ctrl.sv
// Directed and randomized bench for rx_host_buffer_ctrl, checked against a queue-based buffer model.
module tb_rx_host_buffer_ctrl;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              load_buffer;
    logic [DATA_W-1:0] rx_data;
    logic              framing_error;
    logic              data_read;
    logic              clear_errors;
    logic [DATA_W-1:0] rx_out;
    logic              data_ready;
    logic              fifo_full;
    logic [$clog2(DEPTH):0] count;
    logic              overrun_error;
    logic              framing_flag;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] q[$];
    logic              m_ovr;
    logic              m_frm;

    rx_host_buffer_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .load_buffer   (load_buffer),
        .rx_data       (rx_data),
        .framing_error (framing_error),
        .data_read     (data_read),
        .clear_errors  (clear_errors),
        .rx_out        (rx_out),
        .data_ready    (data_ready),
        .fifo_full     (fifo_full),
        .count         (count),
        .overrun_error (overrun_error),
        .framing_flag  (framing_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [DATA_W-1:0] exp_head;
        exp_head = (q.size() > 0) ? q[0] : '0;
        chk({tag, "_count"},   32'(count),         32'(q.size()));
        chk({tag, "_ready"},   32'(data_ready),    32'(q.size() > 0));
        chk({tag, "_full"},    32'(fifo_full),     32'(q.size() == DEPTH));
        chk({tag, "_rx_out"},  32'(rx_out),        32'(exp_head));
        chk({tag, "_overrun"}, 32'(overrun_error), 32'(m_ovr));
        chk({tag, "_framing"}, 32'(framing_flag),  32'(m_frm));
    endtask

    // One clock cycle: drive on the falling edge, update the model at the rising edge, sample 1 ns later.
    task automatic step(input logic lb, input logic [DATA_W-1:0] d, input logic fe,
                        input logic rd, input logic clr);
        logic pop_ok;
        logic push;
        @(negedge clk);
        load_buffer   = lb;
        rx_data       = d;
        framing_error = fe;
        data_read     = rd;
        clear_errors  = clr;
        @(posedge clk);
        pop_ok = rd && (q.size() > 0);
        push   = lb && !fe;
        if (clr) begin
            m_ovr = 1'b0;
            m_frm = 1'b0;
        end
        if (lb && fe) m_frm = 1'b1;
        if (push && q.size() == DEPTH && !pop_ok) begin
            m_ovr = 1'b1;
            push  = 1'b0;
        end
        if (pop_ok) void'(q.pop_front());
        if (push) q.push_back(d);
        #1;
        @(negedge clk);
        load_buffer   = 1'b0;
        framing_error = 1'b0;
        data_read     = 1'b0;
        clear_errors  = 1'b0;
    endtask

    task automatic push_w(input logic [DATA_W-1:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_w();
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovr = 1'b0;
        m_frm = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0;
        load_buffer = 1'b0; rx_data = '0; framing_error = 1'b0;
        data_read = 1'b0; clear_errors = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        n_rst = 1'b1;

        // 1: single word, first-word-fall-through
        push_w(8'hA5);
        check_all("t1_push");
        chk("t1_rx_out_lit", 32'(rx_out), 32'h0000_00A5);
        pop_w();
        check_all("t1_pop");

        // 2: fill, overrun, drain in order
        for (int i = 1; i <= 4; i++) push_w(DATA_W'(i));
        check_all("t2_full");
        chk("t2_full_lit", 32'(fifo_full), 32'd1);
        push_w(8'h05);
        check_all("t2_overrun");
        chk("t2_overrun_lit", 32'(overrun_error), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("t2_order", 32'(rx_out), 32'(i));
            pop_w();
        end
        check_all("t2_drained");
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // 3: push and pop together while full
        for (int i = 0; i < 4; i++) push_w(8'h20 + DATA_W'(i));
        step(1'b1, 8'h10, 1'b0, 1'b1, 1'b0);
        check_all("t3_pushpop_full");
        chk("t3_count_lit", 32'(count), 32'd4);
        for (int i = 0; i < 3; i++) pop_w();
        chk("t3_last_word", 32'(rx_out), 32'h10);
        pop_w();
        check_all("t3_drained");

        // 4: framing errors and clear
        push_w(8'h33);
        step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        check_all("t4_frame");
        chk("t4_frame_lit", 32'(framing_flag), 32'd1);
        step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
        check_all("t4_set_wins");
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_all("t4_cleared");
        chk("t4_cleared_lit", 32'(framing_flag), 32'd0);
        pop_w();

        // 5: wrap-around then asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) push_w(8'h40 + DATA_W'(i));
        for (int i = 0; i < 3; i++) pop_w();
        for (int i = 0; i < 3; i++) push_w(8'h50 + DATA_W'(i));
        check_all("t5_wrap");
        chk("t5_wrap_head", 32'(rx_out), 32'h50);
        push_w(8'h60);
        step(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        model_reset();
        check_all("t5_async_reset");
        @(negedge clk);
        n_rst = 1'b1;

        // 6: pop while empty, push+pop while empty
        pop_w();
        check_all("t6_pop_empty");
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        check_all("t6_pushpop_empty");
        chk("t6_count_lit", 32'(count), 32'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 99) < 60), DATA_W'($urandom),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 15) == 0));
            check_all("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
